pmp_lsu_req_buf: RTL and testbench
==================================

PMP_LSU_REQ_BUF -- requirements
Module: pmp_lsu_req_buf

Purpose: two-entry registered skid buffer between the MMU/LSU address stage and the combinational PMP data check. It cuts the timing path and tolerates back-pressure from the check stage.

Interface
REQ-001 SHALL have parameter PLEN, default 56: physical address width.
REQ-002 SHALL have parameter VLEN, default 64: virtual address width (tval only).
REQ-003 SHALL have parameter XLEN, default 64: exception cause width.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port flush_i, input, 1 bit: discard all buffered requests.
REQ-007 SHALL have port in_valid_i, input, 1 bit: upstream request valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit: buffer can accept a request.
REQ-009 SHALL have port in_paddr_i, input, PLEN bits: physical address.
REQ-010 SHALL have port in_vaddr_i, input, VLEN bits: virtual address.
REQ-011 SHALL have port in_is_store_i, input, 1 bit: request is a store.
REQ-012 SHALL have port in_priv_lvl_i, input, 2 bits: effective load/store privilege.
REQ-013 SHALL have port in_v_i, input, 1 bit: effective virtualisation mode.
REQ-014 SHALL have ports in_exc_valid_i (input, 1 bit) and in_exc_cause_i (input, XLEN bits): upstream MMU/misalign exception.
REQ-015 SHALL have ports out_valid_o, out_paddr_o, out_vaddr_o, out_is_store_o, out_priv_lvl_o, out_v_o, out_exc_valid_o and out_exc_cause_o, all outputs with the same widths as the matching in_* ports: oldest buffered request.
REQ-016 SHALL have port out_ready_i, input, 1 bit: the PMP check stage consumes the head request.
REQ-017 SHALL have port count_o, output, 2 bits: occupancy, range 0..2.

Function
REQ-018 SHALL hold up to 2 entries in FIFO order; every entry stores all in_* payload fields.
REQ-019 SHALL define push as in_valid_i && in_ready_o && !flush_i.
REQ-020 SHALL define pop as out_valid_o && out_ready_i && !flush_i.
REQ-021 SHALL drive in_ready_o as (count_o != 2), decoded from registered state only, with no combinational path from out_ready_i.
REQ-022 SHALL drive out_valid_o as (count_o != 0), with out_* payload taken from the head entry.
REQ-023 SHALL present an accepted request at the outputs on the cycle after the push, giving exactly one cycle of latency.
REQ-024 SHALL update count as follows: push only → +1; pop only → −1; push and pop together → unchanged, with the new entry queued behind the remaining one.
REQ-025 SHALL implement three states, EMPTY (0), ONE (1) and FULL (2), with transitions as in REQ-024.
REQ-026 SHALL never push while in FULL, even if pop is asserted in the same cycle, because in_ready_o is low.
REQ-027 SHALL never pop while in EMPTY; out_ready_i is ignored there.
REQ-028 SHALL give flush_i priority over push and pop: the next state is EMPTY and the same-cycle input is discarded.
REQ-029 SHALL keep out_* payload stable while out_valid_o && !out_ready_i && !flush_i.
REQ-030 SHALL implement head/tail pointers as 1-bit values that wrap modulo 2.
REQ-031 SHALL hold payload fields unchanged when not written; their values are don't-care while their entry is invalid.
REQ-032 SHALL pass exception fields through unmodified; the block never creates exceptions itself.

Reset
REQ-033 SHALL, while rst_i is high and independent of clk_i, force count_o=0, out_valid_o=0, in_ready_o=1 and both pointers to 0.
REQ-034 SHALL drive all payload outputs to 0 during reset.
REQ-035 SHALL, on reset asserted mid-transfer, lose all buffered entries, with no output pulse on deassertion.
REQ-036 SHALL allow the first push on the first rising edge after rst_i deasserts.

Verification
REQ-037 SHALL be verified by scenario 1: single push of paddr=0x8000_1000 with out_ready_i=1 → out_valid_o=1 one cycle later with paddr 0x8000_1000, then count_o returns to 0.
REQ-038 SHALL be verified by scenario 2: three back-to-back pushes A,B,C with out_ready_i=0 → count_o=2 and in_ready_o=0 after B; C is held upstream; raising out_ready_i then delivers A,B,C in order.
REQ-039 SHALL be verified by scenario 3: FULL with simultaneous in_valid_i=1 and out_ready_i=1 → A pops, nothing is pushed, count_o=1, and in_ready_o=1 the next cycle.
REQ-040 SHALL be verified by scenario 4: ONE with simultaneous push and pop for 10 cycles → count_o stays 1 and the output order matches the input order.
REQ-041 SHALL be verified by scenario 5: flush_i with in_valid_i=1 while FULL → count_o=0 next cycle and the flushed-cycle request is never output.
REQ-042 SHALL be verified by scenario 6: rst_i pulsed asynchronously mid-cycle while count_o=2 → outputs reset immediately, and after deassertion the first push appears after one cycle with exc_valid=1 and cause=0x5 preserved.

Source files
------------

// File: rtl/pmp_lsu_req_buf.sv
// Two-entry registered skid buffer between the LSU address stage and the PMP data check.
// Latency: one cycle from an accepted request to its appearance at the out_* ports.
// Backpressure: in_ready_o drops only when both entries are held; it depends on registered state alone.
module pmp_lsu_req_buf #(
    parameter int unsigned PLEN = 56,
    parameter int unsigned VLEN = 64,
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,

    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [PLEN-1:0] in_paddr_i,
    input  logic [VLEN-1:0] in_vaddr_i,
    input  logic            in_is_store_i,
    input  logic [1:0]      in_priv_lvl_i,
    input  logic            in_v_i,
    input  logic            in_exc_valid_i,
    input  logic [XLEN-1:0] in_exc_cause_i,

    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PLEN-1:0] out_paddr_o,
    output logic [VLEN-1:0] out_vaddr_o,
    output logic            out_is_store_o,
    output logic [1:0]      out_priv_lvl_o,
    output logic            out_v_o,
    output logic            out_exc_valid_o,
    output logic [XLEN-1:0] out_exc_cause_o,

    output logic [1:0]      count_o
);

    typedef struct packed {
        logic [PLEN-1:0] paddr;
        logic [VLEN-1:0] vaddr;
        logic            is_store;
        logic [1:0]      priv_lvl;
        logic            v;
        logic            exc_valid;
        logic [XLEN-1:0] exc_cause;
    } req_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   head_q;
    logic   tail_q;
    req_t   mem_q [2];
    req_t   in_req;
    req_t   out_req;
    logic   push;
    logic   pop;

    assign in_req = '{
        paddr:     in_paddr_i,
        vaddr:     in_vaddr_i,
        is_store:  in_is_store_i,
        priv_lvl:  in_priv_lvl_i,
        v:         in_v_i,
        exc_valid: in_exc_valid_i,
        exc_cause: in_exc_cause_i
    };

    // Handshake decode uses registered state only, so no path runs from out_ready_i to in_ready_o.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign count_o     = state_q;

    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    // Head entry drives the outputs; storage is cleared on reset so these read zero then.
    assign out_req         = mem_q[head_q];
    assign out_paddr_o     = out_req.paddr;
    assign out_vaddr_o     = out_req.vaddr;
    assign out_is_store_o  = out_req.is_store;
    assign out_priv_lvl_o  = out_req.priv_lvl;
    assign out_v_o         = out_req.v;
    assign out_exc_valid_o = out_req.exc_valid;
    assign out_exc_cause_o = out_req.exc_cause;

    // Occupancy state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy: flush wins, otherwise push and pop adjust the count.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY:   if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = FULL;
                    else if (pop && !push) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Head/tail pointers wrap naturally as single bits; flush realigns them to entry 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
        end else if (flush_i) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
        end else begin
            if (push) tail_q <= ~tail_q;
            if (pop)  head_q <= ~head_q;
        end
    end

    // Payload storage: written only on push, otherwise held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[tail_q] <= in_req;
        end
    end

endmodule

// File: tb/tb_pmp_lsu_req_buf.sv
module tb_pmp_lsu_req_buf;

    localparam int unsigned PLEN = 56;
    localparam int unsigned VLEN = 64;
    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic [PLEN-1:0] paddr;
        logic [VLEN-1:0] vaddr;
        logic            is_store;
        logic [1:0]      priv_lvl;
        logic            v;
        logic            exc_valid;
        logic [XLEN-1:0] exc_cause;
    } req_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic flush_i;
    logic in_valid_i;
    logic out_ready_i;
    req_t drv;

    logic            in_ready_o;
    logic            out_valid_o;
    logic [PLEN-1:0] out_paddr_o;
    logic [VLEN-1:0] out_vaddr_o;
    logic            out_is_store_o;
    logic [1:0]      out_priv_lvl_o;
    logic            out_v_o;
    logic            out_exc_valid_o;
    logic [XLEN-1:0] out_exc_cause_o;
    logic [1:0]      count_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the buffer is just an ordered list of at most two requests.
    req_t mq[$];

    always #5 clk_i = ~clk_i;

    pmp_lsu_req_buf #(.PLEN(PLEN), .VLEN(VLEN), .XLEN(XLEN)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_paddr_i      (drv.paddr),
        .in_vaddr_i      (drv.vaddr),
        .in_is_store_i   (drv.is_store),
        .in_priv_lvl_i   (drv.priv_lvl),
        .in_v_i          (drv.v),
        .in_exc_valid_i  (drv.exc_valid),
        .in_exc_cause_i  (drv.exc_cause),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_paddr_o     (out_paddr_o),
        .out_vaddr_o     (out_vaddr_o),
        .out_is_store_o  (out_is_store_o),
        .out_priv_lvl_o  (out_priv_lvl_o),
        .out_v_o         (out_v_o),
        .out_exc_valid_o (out_exc_valid_o),
        .out_exc_cause_o (out_exc_cause_o),
        .count_o         (count_o)
    );

    function automatic req_t get_out();
        req_t r;
        r = '{out_paddr_o, out_vaddr_o, out_is_store_o, out_priv_lvl_o,
              out_v_o, out_exc_valid_o, out_exc_cause_o};
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t        r;
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        r.paddr = t[PLEN-1:0];
        t = {$urandom(), $urandom()};
        r.vaddr = t[VLEN-1:0];
        t = {$urandom(), $urandom()};
        r.exc_cause = t[XLEN-1:0];
        t = 64'($urandom());
        r.is_store  = t[0];
        r.priv_lvl  = t[2:1];
        r.v         = t[3];
        r.exc_valid = t[4];
        return r;
    endfunction

    task automatic drive(input logic vld, input req_t r, input logic rdy, input logic fl);
        in_valid_i  = vld;
        drv         = r;
        out_ready_i = rdy;
        flush_i     = fl;
    endtask

    // One clock: decide model push/pop from pre-edge inputs, then apply after the edge.
    task automatic step();
        int   n;
        logic psh, pp, fl;
        req_t cur;
        n   = mq.size();
        fl  = flush_i;
        psh = in_valid_i && (n != 2) && !fl;
        pp  = (n != 0) && out_ready_i && !fl;
        cur = drv;
        @(posedge clk_i);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pp)  mq.delete(0);
            if (psh) mq.push_back(cur);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_i = 1'b1;
        #3;
        n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_o); end
        n_checks++; if (get_out() !== req_t'(0)) begin n_fail++; $display("FAIL reset_payload: got %0h expected 0", get_out()); end
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        mq.delete();
    endtask

    task automatic test_single_push();
        req_t a;
        a = rand_req();
        a.paddr = 56'h8000_1000;
        drive(1'b1, a, 1'b1, 1'b0);
        step();
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", out_valid_o); end
        n_checks++; if (out_paddr_o !== 56'h8000_1000) begin n_fail++; $display("FAIL single_paddr: got %0h expected 80001000", out_paddr_o); end
        n_checks++; if (get_out() !== a) begin n_fail++; $display("FAIL single_payload: got %0h expected %0h", get_out(), a); end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL single_drain_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_back_to_back();
        req_t a, b, c;
        a = rand_req(); b = rand_req(); c = rand_req();
        drive(1'b1, a, 1'b0, 1'b0); step();
        n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL b2b_count_a: got %0d expected 1", count_o); end
        drive(1'b1, b, 1'b0, 1'b0); step();
        n_checks++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL b2b_count_b: got %0d expected 2", count_o); end
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %0b expected 0", in_ready_o); end
        drive(1'b1, c, 1'b0, 1'b0); step();
        n_checks++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL b2b_c_held: got %0d expected 2", count_o); end
        n_checks++; if (get_out() !== a) begin n_fail++; $display("FAIL b2b_stall_stable: got %0h expected %0h", get_out(), a); end
        // FULL with valid and ready together: A pops, C stays upstream.
        drive(1'b1, c, 1'b1, 1'b0); step();
        n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 1", count_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %0b expected 1", in_ready_o); end
        n_checks++; if (get_out() !== b) begin n_fail++; $display("FAIL order_b: got %0h expected %0h", get_out(), b); end
        drive(1'b1, c, 1'b1, 1'b0); step();
        n_checks++; if (get_out() !== c) begin n_fail++; $display("FAIL order_c: got %0h expected %0h", get_out(), c); end
        drive(1'b0, '0, 1'b1, 1'b0); step();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %0b expected 0", out_valid_o); end
    endtask

    task automatic test_streaming();
        req_t items[11];
        for (int i = 0; i < 11; i++) items[i] = rand_req();
        drive(1'b1, items[0], 1'b0, 1'b0); step();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, items[k], 1'b1, 1'b0);
            step();
            n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, count_o); end
            n_checks++; if (get_out() !== items[k]) begin n_fail++; $display("FAIL stream_order[%0d]: got %0h expected %0h", k, get_out(), items[k]); end
        end
        drive(1'b0, '0, 1'b1, 1'b0); step();
    endtask

    task automatic test_flush();
        req_t f;
        f = rand_req();
        drive(1'b1, rand_req(), 1'b0, 1'b0); step();
        drive(1'b1, rand_req(), 1'b0, 1'b0); step();
        drive(1'b1, f, 1'b1, 1'b1); step();
        n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        // Flush while ONE with a request offered: that request must also vanish.
        drive(1'b1, rand_req(), 1'b0, 1'b0); step();
        drive(1'b1, f, 1'b0, 1'b1); step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0); step();
            n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_output[%0d]: got %0b expected 0", k, out_valid_o); end
        end
    endtask

    task automatic test_async_reset();
        req_t e;
        drive(1'b1, rand_req(), 1'b0, 1'b0); step();
        drive(1'b1, rand_req(), 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        mq.delete();
        n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b expected 0", out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %0b expected 1", in_ready_o); end
        n_checks++; if (get_out() !== req_t'(0)) begin n_fail++; $display("FAIL arst_payload: got %0h expected 0", get_out()); end
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0); step();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_no_pulse: got %0b expected 0", out_valid_o); end
        e = rand_req();
        e.exc_valid = 1'b1;
        e.exc_cause = 64'h5;
        drive(1'b1, e, 1'b0, 1'b0); step();
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_first_push: got %0b expected 1", out_valid_o); end
        n_checks++; if (out_exc_valid_o !== 1'b1 || out_exc_cause_o !== 64'h5) begin n_fail++; $display("FAIL arst_exc: got %0b/%0h expected 1/5", out_exc_valid_o, out_exc_cause_o); end
        drive(1'b0, '0, 1'b1, 1'b0); step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, rand_req(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
            step();
            n_checks++; if (count_o !== 2'(mq.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", k, count_o, mq.size()); end
            n_checks++; if (in_ready_o !== (mq.size() != 2)) begin n_fail++; $display("FAIL rand_ready[%0d]: got %0b expected %0b", k, in_ready_o, mq.size() != 2); end
            n_checks++; if (out_valid_o !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %0b expected %0b", k, out_valid_o, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_checks++; if (get_out() !== mq[0]) begin n_fail++; $display("FAIL rand_head[%0d]: got %0h expected %0h", k, get_out(), mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_streaming();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
